// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth signed multiplier, one step per clock.
// Ports: clk, reset (sync, active-high), start/a/b in; busy, done, product out.
// Optional macro BOOTH_START_ERR_EN adds output start_err (rejected-start pulse).
module booth_seq_mult #(
   parameter int  WIDTH = 16,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
`ifdef BOOTH_START_ERR_EN
   ,
   output logic               start_err
`endif
);

   // P = {A[WIDTH:0], Q[WIDTH-1:0], q_m1}
   localparam int PW = 2*WIDTH + 2;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic [PW-1:0]      p_q, p_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;

   logic [WIDTH:0]     acc;
   logic [WIDTH:0]     m_ext;
   logic [WIDTH:0]     acc_nxt;
   logic [PW-1:0]      p_shift;
   logic               last_step;

   // Booth step datapath; A carries an extra bit so A - (-2^(W-1)) fits.
   always_comb begin
      acc     = p_q[PW-1:WIDTH+1];
      m_ext   = {m_q[WIDTH-1], m_q};
      acc_nxt = acc;
      case (p_q[1:0])
         2'b01:   acc_nxt = acc + m_ext;
         2'b10:   acc_nxt = acc - m_ext;
         default: acc_nxt = acc;
      endcase
      // arithmetic shift: replicate new A sign, drop old q_m1
      p_shift = {acc_nxt[WIDTH], acc_nxt, p_q[WIDTH:1]};
   end

   assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               m_d     = a;
               p_d     = {{(WIDTH+1){1'b0}}, b, 1'b0};
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            p_d   = p_shift;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) begin
               state_d = DONE;
               prod_d  = p_shift[2*WIDTH:1];
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         m_q     <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign product = prod_q;

`ifdef BOOTH_START_ERR_EN
   logic err_q, err_d;

   assign err_d = start && (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign start_err = err_q;
`endif

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: directed checks of booth_seq_mult (WIDTH=16)
// plus an exhaustive WIDTH=4 instance against a signed reference.
module tb_booth_seq_mult;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [31:0] product;

   logic        start4;
   logic [3:0]  a4;
   logic [3:0]  b4;
   logic        busy4;
   logic        done4;
   logic [7:0]  product4;

`ifdef BOOTH_START_ERR_EN
   logic        start_err;
   logic        start_err4;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   booth_seq_mult #(.WIDTH(16)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .product   (product)
`ifdef BOOTH_START_ERR_EN
      ,
      .start_err (start_err)
`endif
   );

   booth_seq_mult #(.WIDTH(4)) u_dut4 (
      .clk       (clk),
      .reset     (reset),
      .start     (start4),
      .a         (a4),
      .b         (b4),
      .busy      (busy4),
      .done      (done4),
      .product   (product4)
`ifdef BOOTH_START_ERR_EN
      ,
      .start_err (start_err4)
`endif
   );

   // Launch one 16-bit multiply; return done latency (0 on timeout).
   task automatic do_mult16(input logic [15:0] av, input logic [15:0] bv,
                            output int lat, output int nbusy);
      @(negedge clk);
      start = 1'b1;
      a     = av;
      b     = bv;
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      nbusy = 0;
      for (int i = 1; i <= 40; i++) begin
         if (busy) nbusy++;
         if (done) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      start  = 1'b0;
      start4 = 1'b0;
      a  = '0;
      b  = '0;
      a4 = '0;
      b4 = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
         errors++;
         $display("FAIL reset16 busy=%b done=%b prod=%h want 0 0 0",
                  busy, done, product);
      end
      checks++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || product4 !== 8'h0) begin
         errors++;
         $display("FAIL reset4 busy=%b done=%b prod=%h want 0 0 0",
                  busy4, done4, product4);
      end
`ifdef BOOTH_START_ERR_EN
      checks++;
      if (start_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_err got %b want 0", start_err);
      end
`endif
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int lat;
      int nb;
      do_mult16(16'd3, 16'd5, lat, nb);
      checks++;
      if (lat !== 17) begin
         errors++;
         $display("FAIL basic_lat got %0d want 17", lat);
      end
      checks++;
      if (nb !== 16) begin
         errors++;
         $display("FAIL basic_busy got %0d want 16", nb);
      end
      checks++;
      if (product !== 32'h0000000F) begin
         errors++;
         $display("FAIL basic_prod got %h want 0000000f", product);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== 32'h0000000F) begin
         errors++;
         $display("FAIL basic_pulse done=%b busy=%b prod=%h want 0 0 0000000f",
                  done, busy, product);
      end
   endtask

   task automatic test_signed();
      logic [15:0] va [3];
      logic [15:0] vb [3];
      logic [31:0] vp [3];
      int lat;
      int nb;
      va[0] = 16'hFFFD; vb[0] = 16'h0005; vp[0] = 32'hFFFFFFF1;
      va[1] = 16'h8000; vb[1] = 16'h8000; vp[1] = 32'h40000000;
      va[2] = 16'h7FFF; vb[2] = 16'h8000; vp[2] = 32'hC0008000;
      for (int k = 0; k < 3; k++) begin
         do_mult16(va[k], vb[k], lat, nb);
         checks++;
         if (lat !== 17 || product !== vp[k]) begin
            errors++;
            $display("FAIL signed%0d lat=%0d prod=%h want 17 %h",
                     k, lat, product, vp[k]);
         end
      end
   endtask

   task automatic test_zero();
      int lat;
      int nb;
      do_mult16(16'h0000, 16'h1234, lat, nb);
      checks++;
      if (lat !== 17 || nb !== 16 || product !== 32'h0) begin
         errors++;
         $display("FAIL zero lat=%0d busy=%0d prod=%h want 17 16 0",
                  lat, nb, product);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      int nb;
      int bad;
      do_mult16(16'd2, 16'd3, lat, nb);
      checks++;
      if (product !== 32'h6) begin
         errors++;
         $display("FAIL b2b_first got %h want 00000006", product);
      end
      @(negedge clk);
      start = 1'b1;
      a     = 16'hFFFF;
      b     = 16'h0004;
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      bad   = 0;
      for (int i = 1; i <= 40; i++) begin
         if (done) begin
            lat = i;
            break;
         end
         if (product !== 32'h6) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL b2b_hold got %0d changes want 0", bad);
      end
      checks++;
      if (lat !== 17 || product !== 32'hFFFFFFFC) begin
         errors++;
         $display("FAIL b2b_second lat=%0d prod=%h want 17 fffffffc",
                  lat, product);
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      int ndone;
      int nerr;
      @(negedge clk);
      start = 1'b1;
      a     = 16'd3;
      b     = 16'd5;
      @(negedge clk);
      a     = 16'd7;
      b     = 16'd9;
      lat   = 0;
      nerr  = 0;
      for (int i = 1; i <= 40; i++) begin
`ifdef BOOTH_START_ERR_EN
         if (start_err) nerr++;
`endif
         if (done) begin
            lat   = i;
            start = 1'b0;
            break;
         end
         @(negedge clk);
      end
      ndone = (lat != 0) ? 1 : 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) ndone++;
`ifdef BOOTH_START_ERR_EN
         if (start_err) nerr++;
`endif
      end
      checks++;
      if (lat !== 17 || product !== 32'h0000000F) begin
         errors++;
         $display("FAIL ign_result lat=%0d prod=%h want 17 0000000f",
                  lat, product);
      end
      checks++;
      if (ndone !== 1) begin
         errors++;
         $display("FAIL ign_done got %0d pulses want 1", ndone);
      end
`ifdef BOOTH_START_ERR_EN
      checks++;
      if (nerr !== 16) begin
         errors++;
         $display("FAIL ign_err got %0d pulses want 16", nerr);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int lat;
      int nb;
      int ndone;
      @(negedge clk);
      start = 1'b1;
      a     = 16'h1234;
      b     = 16'h0011;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
         errors++;
         $display("FAIL rstmid busy=%b done=%b prod=%h want 0 0 0",
                  busy, done, product);
      end
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      checks++;
      if (ndone !== 0) begin
         errors++;
         $display("FAIL rstmid_quiet got %0d active cycles want 0", ndone);
      end
      do_mult16(16'd7, 16'hFFF7, lat, nb);
      checks++;
      if (lat !== 17 || product !== 32'hFFFFFFC1) begin
         errors++;
         $display("FAIL rstmid_fresh lat=%0d prod=%h want 17 ffffffc1",
                  lat, product);
      end
   endtask

   task automatic test_w4_exhaustive();
      int lat;
      logic [7:0] want;
      for (int ia = -8; ia < 8; ia++) begin
         for (int ib = -8; ib < 8; ib++) begin
            want = 8'(ia * ib);
            @(negedge clk);
            start4 = 1'b1;
            a4     = 4'(ia);
            b4     = 4'(ib);
            @(negedge clk);
            start4 = 1'b0;
            lat    = 0;
            for (int i = 1; i <= 20; i++) begin
               if (done4) begin
                  lat = i;
                  break;
               end
               @(negedge clk);
            end
            checks++;
            if (lat !== 5) begin
               errors++;
               $display("FAIL w4_lat a=%0d b=%0d got %0d want 5", ia, ib, lat);
            end
            checks++;
            if (product4 !== want) begin
               errors++;
               $display("FAIL w4_prod a=%0d b=%0d got %h want %h",
                        ia, ib, product4, want);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_zero();
      test_back_to_back();
      test_ignore_start();
      test_reset_mid();
      test_w4_exhaustive();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
